// File: rtl/cbi980_pkg.sv
// rtl/cbi980_pkg.sv - shared FSM states, AXI response codes and AXI attribute constants for cbi980
package cbi980_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] AXI_CACHE = 4'b0000;
  localparam logic [2:0] AXI_PROT  = 3'b000;

  // Both error codes share bit 1; EXOKAY is not expected on AXI4-Lite.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/cbi980_wdog.sv
// rtl/cbi980_wdog.sv - transaction watchdog; sets a sticky hang flag after TIMEOUT busy cycles
module cbi980_wdog #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic aclk,
  input  logic arst,
  input  logic run,
  input  logic clr,
  output logic hang
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hang_q, hang_d;

  always_comb begin
    cnt_d  = cnt_q;
    hang_d = hang_q;
    if (clr) begin
      cnt_d  = '0;
      hang_d = 1'b0;
    end else if (run) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) hang_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      cnt_q  <= '0;
      hang_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hang_q <= hang_d;
    end
  end

  assign hang = hang_q;

endmodule

// File: rtl/cbi980_axil_init.sv
// rtl/cbi980_axil_init.sv - single-outstanding command to AXI4-Lite initiator
// Optional watchdog and hang port enabled by defining CBI980_WDOG_EN.
module cbi980_axil_init
  import cbi980_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] awaddr,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
`ifdef CBI980_WDOG_EN
  ,
  output logic        hang
`endif
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = {cmd_addr[31:2], 2'b00};
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_we) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Address and data channels may complete in either order.
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = resp_is_err(bresp);
        end
      end
      RD_REQ: begin
        if (arready) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (rvalid) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata;
          rsp_err_d   = resp_is_err(rresp);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign awaddr    = addr_q;
  assign awcache   = AXI_CACHE;
  assign awprot    = AXI_PROT;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = addr_q;
  assign arcache   = AXI_CACHE;
  assign arprot    = AXI_PROT;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

`ifdef CBI980_WDOG_EN
  logic wdog_run;
  assign wdog_run = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                    (state_q == RD_REQ) || (state_q == RD_RESP);

  cbi980_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .aclk (aclk),
    .arst (arst),
    .run  (wdog_run),
    .clr  (rsp_valid_q && rsp_ready),
    .hang (hang)
  );

  logic unused_ok;
  assign unused_ok = ^{cmd_addr[1:0]};
`else
  logic unused_ok;
  assign unused_ok = ^{cmd_addr[1:0], TIMEOUT};
`endif

endmodule

// File: tb/tb_cbi980_axil_init.sv
// tb/tb_cbi980_axil_init.sv - directed self-checking bench for cbi980_axil_init
// Watchdog checks are compiled in when CBI980_WDOG_EN is defined.
module tb_cbi980_axil_init;
  import cbi980_pkg::*;

`ifdef CBI980_WDOG_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 1023;
`endif

  logic        aclk = 1'b0;
  logic        arst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awcache, arcache, wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
`ifdef CBI980_WDOG_EN
  logic        hang;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int ar_cycles;
  logic [31:0] held_rdata;

  always #5 aclk = ~aclk;

  cbi980_axil_init #(.TIMEOUT(TO)) dut (
    .aclk(aclk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awaddr(awaddr), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef CBI980_WDOG_EN
    , .hang(hang)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = RESP_OKAY;
    arready = 0; rvalid = 0; rdata = 0; rresp = RESP_OKAY;
    tick();
    tick();
    arst = 1'b0;
    tick();

    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    check("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);

    // Write, both channels accepted in the same cycle, OKAY response
    send_cmd(1'b1, 32'h0000_0013, 32'hDEAD_BEEF, 4'hF);
    check("w1_awaddr", awaddr, 32'h0000_0010);
    check("w1_wdata", wdata, 32'hDEAD_BEEF);
    check("w1_wstrb", 32'(wstrb), 32'hF);
    check("w1_cache_prot", {25'd0, awcache, awprot}, 32'd0);
    check("w1_aw_w_valid", {30'd0, awvalid, wvalid}, 32'd3);
    check("w1_cmd_ready", 32'(cmd_ready), 32'd0);
    awready = 1; wready = 1;
    tick();
    awready = 0; wready = 0;
    check("w1_valids_drop", {30'd0, awvalid, wvalid}, 32'd0);
    check("w1_bready", 32'(bready), 32'd1);
    bvalid = 1; bresp = RESP_OKAY;
    tick();
    bvalid = 0;
    check("w1_bready_done", 32'(bready), 32'd0);
    check("w1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("w1_rsp", {31'd0, rsp_err}, 32'd0);
    check("w1_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("w1_back_idle", {30'd0, rsp_valid, cmd_ready}, 32'd1);

    // Write, wready three cycles ahead of awready, SLVERR response
    send_cmd(1'b1, 32'h0000_0020, 32'h0000_00A5, 4'h3);
    check("w2_awaddr", awaddr, 32'h0000_0020);
    wready = 1;
    tick();
    wready = 0;
    check("w2_wvalid_drop", {30'd0, awvalid, wvalid}, 32'd2);
    check("w2_no_bready", 32'(bready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("w2_aw_held", {29'd0, awvalid, wvalid, bready}, 32'd4);
    end
    awready = 1;
    tick();
    awready = 0;
    check("w2_aw_drop_bready", {29'd0, awvalid, wvalid, bready}, 32'd1);
    bvalid = 1; bresp = RESP_SLVERR;
    tick();
    bvalid = 0; bresp = RESP_OKAY;
    check("w2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("w2_rsp_err", 32'(rsp_err), 32'd1);
    check("w2_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // Read, arready delayed five cycles, DECERR response
    send_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    check("r1_araddr", araddr, 32'h0000_0008);
    check("r1_ar_attr", {25'd0, arcache, arprot}, 32'd0);
    ar_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (arvalid) ar_cycles++;
      tick();
    end
    if (arvalid) ar_cycles++;
    arready = 1;
    tick();
    arready = 0;
    check("r1_arvalid_cycles", 32'(ar_cycles), 32'd6);
    check("r1_ar_drop_rready", {30'd0, arvalid, rready}, 32'd1);
    rvalid = 1; rdata = 32'h1234_5678; rresp = RESP_DECERR;
    tick();
    rvalid = 0; rdata = 32'h0; rresp = RESP_OKAY;
    check("r1_rready_drop", 32'(rready), 32'd0);
    check("r1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("r1_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check("r1_rsp_err", 32'(rsp_err), 32'd1);

    // Response back-pressure with a competing command pulse
    held_rdata = rsp_rdata;
    cmd_we = 1; cmd_addr = 32'h40; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = (i < 2);
      tick();
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, held_rdata);
      check("bp_rsp_err", 32'(rsp_err), 32'd1);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_no_issue", {30'd0, awvalid, arvalid}, 32'd0);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("bp_done", {30'd0, rsp_valid, cmd_ready}, 32'd1);
    tick();
    check("bp_not_queued", {29'd0, awvalid, wvalid, arvalid}, 32'd0);

    // Asynchronous reset while the write request is pending
    send_cmd(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'hF);
    check("ar_pre_awvalid", 32'(awvalid), 32'd1);
    #2;
    arst = 1'b1;
    #1;
    check("ar_valids_clear", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    check("ar_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    #1;
    arst = 1'b0;
    tick();
    check("ar_stays_idle", {29'd0, awvalid, wvalid, cmd_ready}, 32'd1);

`ifdef CBI980_WDOG_EN
    // Watchdog: bvalid withheld for 20 cycles
    send_cmd(1'b1, 32'h0000_0044, 32'h0000_0001, 4'h1);
    awready = 1; wready = 1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin awready = 0; wready = 0; end
      check("wd_hang", 32'(hang), (c >= 9) ? 32'd1 : 32'd0);
      if (c >= 2) check("wd_axi_quiet", {29'd0, awvalid, wvalid, bready}, 32'd1);
      tick();
    end
    bvalid = 1;
    tick();
    bvalid = 0;
    check("wd_hang_in_rsp", {30'd0, hang, rsp_valid}, 32'd3);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("wd_hang_cleared", 32'(hang), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
